// File: rtl/apb_router_responder.sv
// APB register slave plus bit-serial router: frames of {2 dest bits, DATA_W payload} are re-serialised onto one of four ports.
// Latency: prdata one edge after setup; TX starts one edge after the last payload bit. No backpressure: busy or masked frames are dropped.
module apb_router_responder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic        valid_in,
    input  logic        data_in,
    output logic        valid_out,
    output logic        out_port1,
    output logic        out_port2,
    output logic        out_port3,
    output logic        out_port4
);
    localparam int DCW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_DATA} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    rx_state_t          r_rx_state;
    logic [DCW-1:0]     r_rx_cnt;
    logic [1:0]         r_rx_dest;
    logic [DATA_W-1:0]  r_rx_shift;

    tx_state_t          r_tx_state;
    logic [DCW-1:0]     r_tx_cnt;
    logic [1:0]         r_tx_port;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_valid_out;
    logic [3:0]         r_out;

    logic               r_enable;
    logic [3:0]         r_port_en;
    logic [31:0]        r_scratch;
    logic [CNT_W-1:0]   r_pkt_cnt [4];
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_addr_ok;
    logic [2:0]         w_idx;
    logic               w_setup_rd;
    logic               w_wr;
    logic               w_clr;
    logic [31:0]        w_rdata;
    logic [DATA_W-1:0]  w_rx_word;
    logic               w_rx_last;
    logic               w_abort;
    logic               w_accept;
    logic               w_drop;
    logic               w_pkt_inc;

    assign w_addr_ok  = (paddr[31:5] == 27'd0) && (paddr[1:0] == 2'd0);
    assign w_idx      = paddr[4:2];
    assign w_setup_rd = psel && !penable && !pwrite;
    assign w_wr       = psel && penable && pwrite && w_addr_ok;
    assign w_clr      = w_wr && (w_idx == 3'd0) && pwdata[8];

    // Payload bits arrive LSB first, so shift in from the top.
    assign w_rx_word  = {data_in, r_rx_shift[DATA_W-1:1]};
    assign w_rx_last  = (r_rx_state == RX_DATA) && valid_in && (r_rx_cnt == DCW'(DATA_W - 1));
    assign w_abort    = (r_rx_state != RX_IDLE) && !valid_in;
    assign w_accept   = w_rx_last && r_enable && r_port_en[r_rx_dest] && (r_tx_state == TX_IDLE);
    assign w_drop     = (w_rx_last && !w_accept) || w_abort;
    assign w_pkt_inc  = (r_tx_state == TX_SEND) && (r_tx_cnt == DCW'(DATA_W - 1));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_rdata = 32'd0;
        if (w_addr_ok) begin
            case (w_idx)
                3'd0: w_rdata = {27'd0, r_port_en, r_enable};
                3'd1: w_rdata = {28'd0, r_tx_port, (r_tx_state == TX_SEND), (r_rx_state != RX_IDLE)};
                3'd2: w_rdata = 32'(r_pkt_cnt[0]);
                3'd3: w_rdata = 32'(r_pkt_cnt[1]);
                3'd4: w_rdata = 32'(r_pkt_cnt[2]);
                3'd5: w_rdata = 32'(r_pkt_cnt[3]);
                3'd6: w_rdata = 32'(r_drop_cnt);
                default: w_rdata = r_scratch;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata    <= 32'd0;
            r_enable  <= 1'b1;
            r_port_en <= 4'hF;
            r_scratch <= 32'd0;
        end else begin
            if (w_setup_rd)
                prdata <= w_rdata;
            if (w_wr && w_idx == 3'd0) begin
                r_enable  <= pwdata[0];
                r_port_en <= pwdata[4:1];
            end
            if (w_wr && w_idx == 3'd7)
                r_scratch <= pwdata;
        end
    end

    // A clear write wins over any increment landing on the same edge.
    always_ff @(posedge pclk) begin
        if (preset || w_clr) begin
            for (int i = 0; i < 4; i++)
                r_pkt_cnt[i] <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pkt_inc)
                r_pkt_cnt[r_tx_port] <= sat_inc(r_pkt_cnt[r_tx_port]);
            if (w_drop)
                r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_dest  <= 2'd0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (valid_in) begin
                        r_rx_dest[0] <= data_in;
                        r_rx_state   <= RX_HDR;
                    end
                end
                RX_HDR: begin
                    if (!valid_in) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_dest[1] <= data_in;
                        r_rx_cnt     <= '0;
                        r_rx_state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (!valid_in) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_shift <= w_rx_word;
                        if (w_rx_last)
                            r_rx_state <= RX_IDLE;
                        else
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_port   <= 2'd0;
            r_tx_data   <= '0;
            r_valid_out <= 1'b0;
            r_out       <= 4'd0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_accept) begin
                        r_tx_state  <= TX_SEND;
                        r_tx_cnt    <= '0;
                        r_tx_port   <= r_rx_dest;
                        r_tx_data   <= w_rx_word;
                        r_valid_out <= 1'b1;
                        r_out       <= {3'd0, w_rx_word[0]} << r_rx_dest;
                    end
                end
                TX_SEND: begin
                    if (w_pkt_inc) begin
                        r_tx_state  <= TX_IDLE;
                        r_valid_out <= 1'b0;
                        r_out       <= 4'd0;
                    end else begin
                        r_tx_cnt  <= r_tx_cnt + 1'b1;
                        r_tx_data <= r_tx_data >> 1;
                        r_out     <= {3'd0, r_tx_data[1]} << r_tx_port;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign valid_out = r_valid_out;
    assign out_port1 = r_out[0];
    assign out_port2 = r_out[1];
    assign out_port3 = r_out[2];
    assign out_port4 = r_out[3];
endmodule

// File: tb/tb_apb_router_responder.sv
// Scoreboard bench for apb_router_responder: APB read results and serial output bits are queued at stimulus time.
// Counter width is shrunk so saturation is reachable in a short run.
module tb_apb_router_responder;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int FW     = DATA_W + 2;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic        pclk, preset;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, valid_in, data_in;
    logic        valid_out, out_port1, out_port2, out_port3, out_port4;

    apb_router_responder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pwrite(pwrite), .psel(psel), .penable(penable), .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out), .out_port1(out_port1), .out_port2(out_port2),
        .out_port3(out_port3), .out_port4(out_port4)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  tx_q [$];
    logic [31:0] rd_q [$];
    logic [3:0]  mon_exp;
    logic [3:0]  ports;

    assign ports = {out_port4, out_port3, out_port2, out_port1};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] dat);
        paddr = addr; pwdata = dat; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        rd_q.push_back(exp);
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        check_val(tag, prdata, rd_q.pop_front());
    endtask

    // Drives nbits of a frame; when routed, the expected output bits are queued first.
    task automatic send_frame(input logic [1:0] dest, input logic [DATA_W-1:0] pay,
                              input int nbits, input bit routed, input bit keep_valid);
        logic [FW-1:0] fr;
        fr = {pay, dest};
        if (routed)
            for (int i = 0; i < DATA_W; i++)
                tx_q.push_back({3'd0, pay[i]} << dest);
        for (int i = 0; i < nbits; i++) begin
            valid_in = 1'b1;
            data_in  = fr[i];
            tick();
        end
        if (nbits == FW)
            check_val("vld_start", {31'd0, valid_out}, {31'd0, routed});
        if (!keep_valid) begin
            valid_in = 1'b0;
            data_in  = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * FW && tx_q.size() != 0; i++)
            tick();
        check_val("tx_drain", tx_q.size(), 0);
        tx_q.delete();
        tick();
        tick();
    endtask

    always @(negedge pclk) begin
        if (!preset) begin
            if (valid_out) begin
                if (tx_q.size() == 0) begin
                    check_val("tx_unexpected", {31'd0, valid_out}, 32'd0);
                end else begin
                    mon_exp = tx_q.pop_front();
                    check_val("tx_bit", {28'd0, ports}, {28'd0, mon_exp});
                end
            end else if (ports != 4'd0) begin
                check_val("idle_ports", {28'd0, ports}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; paddr = 0; pwdata = 0; pwrite = 0; psel = 0; penable = 0;
        valid_in = 0; data_in = 0;
        repeat (3) tick();
        preset = 1'b0;
        tick();
        check_val("rst_prdata", prdata, 32'd0);
        check_val("rst_vld", {31'd0, valid_out}, 32'd0);
        check_val("rst_ports", {28'd0, ports}, 32'd0);

        apb_read(32'h00, 32'h1F, "rst_ctrl");
        apb_read(32'h04, 32'h0,  "rst_status");
        for (int a = 2; a < 7; a++)
            apb_read(32'(a * 4), 32'h0, "rst_cnt");
        apb_read(32'h1C, 32'h0, "rst_scratch");

        apb_write(32'h1C, 32'hA5A5_5A5A);
        apb_read(32'h1C, 32'hA5A5_5A5A, "scratch_rw");
        apb_write(32'h0C, 32'h1234);
        apb_read(32'h0C, 32'h0, "ro_write");
        apb_read(32'h20, 32'h0, "unmapped_20");
        apb_read(32'h100, 32'h0, "unmapped_100");

        send_frame(2'd2, 8'hC3, FW, 1'b1, 1'b0);
        drain();
        apb_read(32'h10, 32'h1, "pkt_cnt3");
        apb_read(32'h04, 32'h8, "status_port");

        apb_write(32'h00, 32'h1D);
        send_frame(2'd0, 8'h55, FW, 1'b0, 1'b0);
        drain();
        apb_read(32'h18, 32'h1, "drop_masked");
        apb_read(32'h08, 32'h0, "pkt_cnt1_masked");

        apb_write(32'h00, 32'h1E);
        send_frame(2'd1, 8'hAA, FW, 1'b0, 1'b0);
        drain();
        apb_read(32'h18, 32'h2, "drop_disabled");

        apb_write(32'h00, 32'h1F);
        send_frame(2'd3, 8'h0F, 5, 1'b0, 1'b0);
        tick();
        apb_read(32'h04, 32'h8, "abort_idle");
        apb_read(32'h18, 32'h3, "drop_abort");
        send_frame(2'd3, 8'h5A, FW, 1'b1, 1'b0);
        drain();
        apb_read(32'h14, 32'h1, "pkt_cnt4");

        for (int f = 0; f <= int'(CNT_MAX) + 1; f++)
            send_frame(2'd0, 8'(f * 37 + 1), FW, 1'b1, 1'b1);
        valid_in = 1'b0;
        data_in  = 1'b0;
        drain();
        apb_read(32'h08, CNT_MAX, "pkt_cnt1_sat");

        // Land the clear write's access edge on the final SEND edge of this frame.
        send_frame(2'd1, 8'h81, FW, 1'b1, 1'b0);
        repeat (DATA_W - 2) tick();
        apb_write(32'h00, 32'h11F);
        drain();
        for (int a = 2; a < 7; a++)
            apb_read(32'(a * 4), 32'h0, "clr_cnt");
        apb_read(32'h00, 32'h1F, "ctrl_clr_bit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/apb_router_responder.md
# apb_router_responder

APB responder and serial router that sits at the far end of the APB bus driven by the agent's master. It decodes zero-wait-state APB transfers into a small register map: control, status, per-port packet counters, drop counter and scratch. It also deserialises bit-serial frames on `valid_in`/`data_in` and re-serialises each frame's payload onto one of four output ports. The RAL model maps one-to-one onto the register map defined here.

## Interface
Parameters:
- `DATA_W`, 8: payload bits per frame.
- `CNT_W`, 16: width of each counter. Counters are zero-extended to 32 bits on read.

Ports:
- `pclk`  in  1  clock; all logic is on the rising edge.
- `preset`  in  1  reset, synchronous and active-high.
- `paddr`  in  32  APB address.
- `pwdata`  in  32  APB write data.
- `prdata`  out  32  APB read data.
- `pwrite`  in  1  1 = write, 0 = read.
- `psel`  in  1  APB select.
- `penable`  in  1  APB access phase.
- `valid_in`  in  1  serial frame valid.
- `data_in`  in  1  serial frame bit, LSB first.
- `valid_out`  out  1  high while a payload bit is on the selected port.
- `out_port1`..`out_port4`  out  1 each  serial payload outputs.

## Operation
Reset clears all registers, counters and both FSMs.
- Outputs after reset: `prdata` = 0, `valid_out` = 0, `out_port1`..`4` = 0.
- Reset state: CTRL = 0x0000_001F, so the block is enabled with all ports unmasked. SCRATCH = 0.

Register map. Only `paddr[31:5]` = 0 and `paddr[1:0]` = 0 decode; any other address is unmapped. Unmapped reads return 0 and unmapped writes are ignored.
- 0x00 CTRL RW.
  - [0] `enable`.
  - [4:1] `port_en[3:0]`.
  - [8] `clr_cnt`: write-1 clears all counters. This bit is self-clearing and reads 0.
  - All other bits read 0.
- 0x04 STATUS RO.
  - [0] `rx_busy`.
  - [1] `tx_busy`.
  - [3:2] port of the current or last TX frame.
- 0x08, 0x0C, 0x10, 0x14: `PKT_CNT1`..`4` RO. Count frames transmitted per port.
- 0x18 DROP_CNT RO. Counts frames dropped or aborted.
- 0x1C SCRATCH RW, full 32 bits.

APB transfers:
- The setup phase is `psel`=1, `penable`=0. The access phase is `psel`=1, `penable`=1.
- Writes commit on the access-phase edge.
- Reads: `prdata` is loaded on the setup-phase edge so it is valid throughout the access phase. `prdata` holds its value until the next read setup phase.
- A write to a RO register is ignored.

Frame format: 2 header bits (destination port, LSB first, 0→port1 … 3→port4) followed by `DATA_W` payload bits, LSB first. `valid_in` is high on every bit.

RX FSM: IDLE → HDR (2 bits) → DATA (`DATA_W` bits) → IDLE.
- IDLE→HDR on the first sample with `valid_in`=1. That sample is header bit 0.
- When the last payload bit is sampled, the frame is accepted or dropped:
  - accepted if `enable`=1, `port_en[dest]`=1 and TX is IDLE;
  - otherwise dropped, and DROP_CNT increments.
- If `valid_in`=0 in HDR or DATA, the frame is aborted: RX returns to IDLE and DROP_CNT increments.
- If `enable`=0, frames are still deserialised and then dropped.

TX FSM: IDLE → SEND (`DATA_W` cycles) → IDLE.
- In SEND, `valid_out`=1 and the selected `out_portN` carries the payload bit, LSB first.
- Unselected ports are held at 0.
- PKT_CNT[dest] increments on the last SEND cycle.

Counters:
- Counters saturate at 2^`CNT_W`−1.
- A `clr_cnt` write in the same cycle as an increment takes priority, so the counter becomes 0.

## Timing
- APB: zero wait states. Every transfer is 2 cycles. Back-to-back transfers are allowed: access phase then setup phase, with no idle cycle.
- A register write is visible to a read whose setup phase is in the cycle after the write's access phase.
- RX latency: when the last payload bit is sampled at edge k, TX enters SEND at edge k+1. `valid_out` is high in cycles k+1 through k+`DATA_W`.
- Back-to-back frames (`valid_in` continuously high, 2+`DATA_W` cycles per frame) never collide, because TX finishes before the next frame completes.
- A TX-busy drop occurs only if `DATA_W` is redefined so that TX is longer than a frame. The check stays in the RTL.
- A CTRL change mid-frame takes effect at the frame-completion check. It does not affect a frame already in SEND.
- Reset asserted mid-frame or mid-SEND:
  - the next edge forces both FSMs to IDLE and `valid_out`=0;
  - counters return to 0;
  - the partial frame is not counted.

## Test plan
- Reset value check: after `preset`, read all 8 addresses. Required values: CTRL = 0x1F, STATUS = 0, every counter = 0, SCRATCH = 0, and `prdata` = 0 before any read.
- RW access: write SCRATCH = 0xA5A5_5A5A and read it back as 0xA5A5_5A5A. A write to 0x0C does not change that register. A read of 0x20 returns 0. A read of 0x100 returns 0.
- Routing: send a frame with dest 2 and payload 0xC3.
  - `out_port3` carries 1,1,0,0,0,0,1,1 over 8 cycles starting 1 cycle after the last input bit, with `valid_out` high for those 8 cycles.
  - The other ports stay at 0.
  - PKT_CNT3 = 1.
- Masking and disable:
  - CTRL = 0x1D (port 1 masked); a frame to dest 0 leaves DROP_CNT = 1 and `valid_out` never rises.
  - CTRL = 0x1E (enable=0); any frame increments DROP_CNT.
- Abort: drop `valid_in` after 5 bits. RX returns to IDLE, DROP_CNT increments by 1, and the next full frame routes correctly.
- Clear and saturation:
  - Force PKT_CNT1 to saturate by streaming 2^`CNT_W` frames; it holds 0xFFFF.
  - Write CTRL[8]=1 coincident with a final PKT_CNT increment; all counters read 0.
